syscall_service_controller: RTL and testbench
=============================================

Name: syscall_service_controller

Overview:
- Sequences syscall requests retired by the dual-issue write-back stage onto a single console output channel.
- Accepts up to two requests per cycle in program order (lane 0 older than lane 1) and buffers them in a FIFO.
- Drains one entry per console handshake and back-pressures the pipeline through a stall request.
- Owns program termination: after the exit syscall drains, the block halts.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- DATA_W, 32, width of the syscall code and argument.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- req_valid0  input  1  lane 0 retires a syscall this cycle.
- req_code0  input  DATA_W  lane 0 $v0 value.
- req_arg0  input  DATA_W  lane 0 $a0 value.
- req_valid1  input  1  lane 1 retires a syscall this cycle.
- req_code1  input  DATA_W  lane 1 $v0 value.
- req_arg1  input  DATA_W  lane 1 $a0 value.
- req_ready  output  1  FIFO can accept two entries this cycle.
- stall_req  output  1  freeze write-back and all earlier stages.
- cons_valid  output  1  console entry available.
- cons_kind  output  2  0 PRINT_INT, 1 EXIT, 2 UNKNOWN.
- cons_data  output  DATA_W  PRINT_INT: argument; UNKNOWN: code; EXIT: 0.
- cons_ready  input  1  console consumes the entry.
- halted  output  1  program terminated.
- proto_err  output  1  sticky; a request was presented while req_ready=0.

Behaviour:
- Reset: FIFO empty, state RUN, cons_valid=0, cons_kind=0, cons_data=0, halted=0, proto_err=0, stall_req=0, req_ready=1. Reset mid-drain discards all queued entries.
- Classification at enqueue:
  - code==1 -> PRINT_INT.
  - code==10 -> EXIT.
  - any other code -> UNKNOWN.
- req_ready=1 only when state==RUN and free entries >= 2. stall_req = !req_ready.
- Accept: when req_ready=1, each valid lane is written in the same cycle, lane 0 first.
  - Both valid -> two writes, lane 0 at the lower FIFO slot.
  - Lane 1 alone valid -> one write.
  - An entry is visible on cons_* no earlier than the next cycle; enqueue-to-output latency is 1 cycle.
- Requests presented with req_ready=0 are ignored and set proto_err. proto_err clears only on rst.
- Output: cons_valid=1 whenever the FIFO is non-empty; cons_kind and cons_data come from the head entry. Pop on cons_valid && cons_ready. cons_* stay stable while cons_valid && !cons_ready.
- Simultaneous push and pop in one cycle is legal. Occupancy updates by pushes minus pop. Pointers wrap modulo DEPTH. The count register is $clog2(DEPTH)+1 bits.
- State machine:
  - RUN -> DRAIN when an EXIT entry is enqueued. If lane 0 is EXIT, the lane 1 request in the same cycle is discarded and does not set proto_err.
  - DRAIN: accept nothing; req_ready=0, stall_req=1. Earlier entries still drain in order.
  - DRAIN -> HALT on the cycle the EXIT entry is popped. halted=1 from the next cycle.
  - HALT: terminal until rst. cons_valid=0, stall_req=1, req_ready=0. Requests are ignored without setting proto_err.
- Full boundary: with free=1, req_ready=0 even if only one lane would request.
- Empty boundary: with the FIFO empty, cons_valid=0 and cons_ready is don't-care.

Decomposition:
- Shared package (sys_pkg) holds:
  - SYS_PRINT_INT=32'd1 and SYS_EXIT=32'd10.
  - The cons_kind_t enum {CK_PRINT_INT, CK_EXIT, CK_UNKNOWN}.
  - A struct syscall_entry_t {cons_kind_t kind; logic [DATA_W-1:0] data;}.
  - The state enum {SC_RUN, SC_DRAIN, SC_HALT}.
- One natural sub-module: dual_push_fifo, a two-write/one-read FIFO of syscall_entry_t with a free-count output. The controller FSM, classification and lane-discard logic stay in the top module.

Test Plan:
- Ordering: cycle 0 with lane0 (1, 7) and lane1 (1, -3), cons_ready=1 -> cons_valid cycles 1–2 with (PRINT_INT, 7) then (PRINT_INT, 32'hFFFFFFFD).
- Back-pressure: cons_ready=0 and DEPTH=4, push 2 then 2 -> after the first push req_ready=1; after the second (free=0) stall_req=1. A lane0 request while stalled -> proto_err=1 and the FIFO is unchanged. Release cons_ready -> 4 outputs in order.
- Unknown code: lane0 (5, x) -> (UNKNOWN, 5).
- Exit drain: queue (1, 42), then lane0 (10, 0) with lane1 (1, 99) in the same cycle, cons_ready held 0 for 3 cycles then 1:
  - outputs are (PRINT_INT, 42) then (EXIT, 0); 99 is never output;
  - proto_err stays 0 and stall_req=1 throughout DRAIN;
  - halted=1 one cycle after the EXIT pop.
- Wrap and reset: 10 single pushes with simultaneous pops stream correctly across pointer wrap. Assert rst with 3 entries queued -> next cycle cons_valid=0, req_ready=1, halted=0.

Source files
------------

// File: rtl/sys_pkg.sv
// Shared types for the syscall console path: syscall codes, console entry
// kinds, the buffered entry format and the controller states.
package sys_pkg;

   localparam int SYS_DATA_W = 32;

   localparam logic [SYS_DATA_W-1:0] SYS_PRINT_INT = 32'd1;
   localparam logic [SYS_DATA_W-1:0] SYS_EXIT      = 32'd10;

   typedef enum logic [1:0] {
      CK_PRINT_INT = 2'd0,
      CK_EXIT      = 2'd1,
      CK_UNKNOWN   = 2'd2
   } cons_kind_t;

   typedef struct packed {
      cons_kind_t              kind;
      logic [SYS_DATA_W-1:0]   data;
   } syscall_entry_t;

   typedef enum logic [1:0] {
      SC_RUN,
      SC_DRAIN,
      SC_HALT
   } sc_state_t;

   // The console only ever needs one payload word, so the choice between
   // argument and code is made once, when the request is buffered.
   function automatic syscall_entry_t classify_syscall(
      input logic [SYS_DATA_W-1:0] code,
      input logic [SYS_DATA_W-1:0] arg
   );
      syscall_entry_t e;
      if (code == SYS_PRINT_INT) begin
         e.kind = CK_PRINT_INT;
         e.data = arg;
      end else if (code == SYS_EXIT) begin
         e.kind = CK_EXIT;
         e.data = '0;
      end else begin
         e.kind = CK_UNKNOWN;
         e.data = code;
      end
      return e;
   endfunction

endpackage

// File: rtl/syscall_service_controller_fifo.sv
// Two-write / one-read FIFO of syscall entries. When both lanes write,
// lane 0 lands in the lower slot; a lone lane 1 write takes the next slot.
module dual_push_fifo
   import sys_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push0,
   input  syscall_entry_t             entry0,
   input  logic                       push1,
   input  syscall_entry_t             entry1,
   input  logic                       pop,
   output syscall_entry_t             head,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     free_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   syscall_entry_t   mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_addr1;
   logic [CW-1:0]    count;
   logic             do_pop;

   always_comb begin
      wr_addr1 = wr_ptr + AW'(push0);
      empty    = (count == '0);
      do_pop   = pop && !empty;
      free_cnt = CW'(DEPTH) - count;
      head     = mem[rd_ptr];
   end

   // Storage is not reset; the pointers and count alone define what is valid.
   always_ff @(posedge clk) begin
      if (push0) mem[wr_ptr]   <= entry0;
      if (push1) mem[wr_addr1] <= entry1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wr_ptr + AW'(push0) + AW'(push1);
         rd_ptr <= rd_ptr + AW'(do_pop);
         count  <= count + CW'(push0) + CW'(push1) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/syscall_service_controller.sv
// Collects syscalls retired by both write-back lanes, serialises them onto the
// console channel, and halts the machine once the exit syscall has drained.
module syscall_service_controller
   import sys_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid0,
   input  logic [DATA_W-1:0]   req_code0,
   input  logic [DATA_W-1:0]   req_arg0,
   input  logic                req_valid1,
   input  logic [DATA_W-1:0]   req_code1,
   input  logic [DATA_W-1:0]   req_arg1,
   output logic                req_ready,
   output logic                stall_req,
   output logic                cons_valid,
   output logic [1:0]          cons_kind,
   output logic [DATA_W-1:0]   cons_data,
   input  logic                cons_ready,
   output logic                halted,
   output logic                proto_err
);

   localparam int CW = $clog2(DEPTH) + 1;

   sc_state_t        state;
   sc_state_t        state_next;
   syscall_entry_t   entry0;
   syscall_entry_t   entry1;
   syscall_entry_t   head;
   logic             fifo_empty;
   logic [CW-1:0]    free_cnt;
   logic             accept;
   logic             push0;
   logic             push1;
   logic             lane0_exit;
   logic             exit_enq;
   logic             pop;
   logic             proto_set;

   dual_push_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push0    (push0),
      .entry0   (entry0),
      .push1    (push1),
      .entry1   (entry1),
      .pop      (pop),
      .head     (head),
      .empty    (fifo_empty),
      .free_cnt (free_cnt)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= SC_RUN;
         proto_err <= 1'b0;
      end else begin
         state <= state_next;
         if (proto_set) proto_err <= 1'b1;
      end
   end

   // Acceptance needs room for both lanes so the pipeline never has to split
   // a retiring pair. Anything younger than an exit in lane 0 is dropped.
   always_comb begin
      entry0     = classify_syscall(SYS_DATA_W'(req_code0), SYS_DATA_W'(req_arg0));
      entry1     = classify_syscall(SYS_DATA_W'(req_code1), SYS_DATA_W'(req_arg1));
      accept     = (state == SC_RUN) && (free_cnt >= CW'(2));
      push0      = accept && req_valid0;
      lane0_exit = push0 && (entry0.kind == CK_EXIT);
      push1      = accept && req_valid1 && !lane0_exit;
      exit_enq   = lane0_exit || (push1 && (entry1.kind == CK_EXIT));
      proto_set  = (state != SC_HALT) && !accept && (req_valid0 || req_valid1);

      req_ready  = accept;
      stall_req  = !accept;
      cons_valid = !fifo_empty && (state != SC_HALT);
      pop        = cons_valid && cons_ready;
      cons_kind  = cons_valid ? head.kind : CK_PRINT_INT;
      cons_data  = cons_valid ? DATA_W'(head.data) : '0;
      halted     = (state == SC_HALT);

      state_next = state;
      case (state)
         SC_RUN:   if (exit_enq) state_next = SC_DRAIN;
         SC_DRAIN: if (pop && (head.kind == CK_EXIT)) state_next = SC_HALT;
         SC_HALT:  state_next = SC_HALT;
         default:  state_next = SC_RUN;
      endcase
   end

endmodule

// File: tb/tb_syscall_service_controller.sv
// Directed bench for syscall_service_controller with a queue-based console
// scoreboard fed at stimulus time and drained by a console monitor.
module tb_syscall_service_controller;

   typedef struct {
      logic [1:0]  kind;
      logic [31:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid0, req_valid1;
   logic [31:0] req_code0, req_arg0, req_code1, req_arg1;
   logic        req_ready, stall_req, cons_valid, cons_ready, halted, proto_err;
   logic [1:0]  cons_kind;
   logic [31:0] cons_data;

   int   errors = 0;
   int   checks = 0;
   exp_t exp_q[$];

   syscall_service_controller #(.DEPTH(4), .DATA_W(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid0 (req_valid0),
      .req_code0  (req_code0),
      .req_arg0   (req_arg0),
      .req_valid1 (req_valid1),
      .req_code1  (req_code1),
      .req_arg1   (req_arg1),
      .req_ready  (req_ready),
      .stall_req  (stall_req),
      .cons_valid (cons_valid),
      .cons_kind  (cons_kind),
      .cons_data  (cons_data),
      .cons_ready (cons_ready),
      .halted     (halted),
      .proto_err  (proto_err)
   );

   always #5 clk = ~clk;

   function automatic exp_t model(input logic [31:0] code, input logic [31:0] arg);
      exp_t e;
      if (code == 32'd1) begin
         e.kind = 2'd0;
         e.data = arg;
      end else if (code == 32'd10) begin
         e.kind = 2'd1;
         e.data = 32'd0;
      end else begin
         e.kind = 2'd2;
         e.data = code;
      end
      return e;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      req_valid0 = 1'b0;
      req_valid1 = 1'b0;
      req_code0  = '0;
      req_arg0   = '0;
      req_code1  = '0;
      req_arg1   = '0;
   endtask

   // Drives one retire cycle; exp_ready is the bench's own prediction of
   // whether the controller can take the pair this cycle.
   task automatic applyStimulus(input logic v0, input logic [31:0] c0, input logic [31:0] a0,
                                input logic v1, input logic [31:0] c1, input logic [31:0] a1,
                                input logic exp_ready);
      req_valid0 = v0;
      req_code0  = c0;
      req_arg0   = a0;
      req_valid1 = v1;
      req_code1  = c1;
      req_arg1   = a1;
      checkOutput("req_ready_pre", req_ready, exp_ready);
      if (exp_ready) begin
         if (v0) exp_q.push_back(model(c0, a0));
         if (v1 && !(v0 && c0 == 32'd10)) exp_q.push_back(model(c1, a1));
      end
      tick();
      idle();
   endtask

   task automatic waitDrain(input int budget);
      for (int i = 0; i < budget; i++) begin
         if (exp_q.size() == 0) break;
         tick();
      end
      checkOutput("drain_left", exp_q.size(), 0);
      checkOutput("drain_valid", cons_valid, 1'b0);
   endtask

   task automatic doReset();
      rst        = 1'b1;
      cons_ready = 1'b0;
      idle();
      exp_q.delete();
      tick();
      rst = 1'b0;
   endtask

   always @(negedge clk) begin
      if (!rst && cons_valid && cons_ready) begin
         if (exp_q.size() == 0) begin
            checkOutput("unexpected_output", cons_data, 32'hFFFF_FFFF ^ cons_data);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            checkOutput("cons_kind", cons_kind, e.kind);
            checkOutput("cons_data", cons_data, e.data);
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst        = 1'b1;
      cons_ready = 1'b0;
      idle();
      tick();
      tick();
      checkOutput("rst_cons_valid", cons_valid, 1'b0);
      checkOutput("rst_cons_kind", cons_kind, 2'd0);
      checkOutput("rst_cons_data", cons_data, 32'd0);
      checkOutput("rst_req_ready", req_ready, 1'b1);
      checkOutput("rst_stall", stall_req, 1'b0);
      checkOutput("rst_halted", halted, 1'b0);
      checkOutput("rst_proto_err", proto_err, 1'b0);
      rst = 1'b0;

      $display("[TB] ordering");
      cons_ready = 1'b1;
      applyStimulus(1'b1, 32'd1, 32'd7, 1'b1, 32'd1, 32'hFFFF_FFFD, 1'b1);
      checkOutput("ord_valid_c1", cons_valid, 1'b1);
      checkOutput("ord_data_c1", cons_data, 32'd7);
      tick();
      checkOutput("ord_data_c2", cons_data, 32'hFFFF_FFFD);
      tick();
      checkOutput("ord_empty_c3", cons_valid, 1'b0);
      waitDrain(10);

      $display("[TB] full boundary");
      cons_ready = 1'b0;
      applyStimulus(1'b1, 32'd1, 32'd200, 1'b1, 32'd1, 32'd201, 1'b1);
      applyStimulus(1'b1, 32'd1, 32'd202, 1'b0, 32'd0, 32'd0, 1'b1);
      checkOutput("free1_req_ready", req_ready, 1'b0);
      checkOutput("free1_stall", stall_req, 1'b1);
      cons_ready = 1'b1;
      waitDrain(20);

      $display("[TB] back-pressure");
      cons_ready = 1'b0;
      applyStimulus(1'b1, 32'd1, 32'd100, 1'b1, 32'd1, 32'd101, 1'b1);
      checkOutput("bp_ready_after2", req_ready, 1'b1);
      applyStimulus(1'b1, 32'd1, 32'd102, 1'b1, 32'd1, 32'd103, 1'b1);
      checkOutput("bp_stall_full", stall_req, 1'b1);
      checkOutput("bp_ready_full", req_ready, 1'b0);
      checkOutput("bp_proto_before", proto_err, 1'b0);
      applyStimulus(1'b1, 32'd1, 32'd555, 1'b0, 32'd0, 32'd0, 1'b0);
      checkOutput("bp_proto_set", proto_err, 1'b1);
      checkOutput("bp_head_kept", cons_data, 32'd100);
      cons_ready = 1'b1;
      waitDrain(20);
      checkOutput("bp_proto_sticky", proto_err, 1'b1);
      doReset();
      checkOutput("bp_proto_cleared", proto_err, 1'b0);

      $display("[TB] unknown and lane1-only");
      cons_ready = 1'b1;
      applyStimulus(1'b1, 32'd5, 32'd77, 1'b0, 32'd0, 32'd0, 1'b1);
      applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 32'd1, 32'd33, 1'b1);
      applyStimulus(1'b1, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 32'd0, 1'b1);
      waitDrain(20);

      $display("[TB] exit drain");
      doReset();
      applyStimulus(1'b1, 32'd1, 32'd42, 1'b0, 32'd0, 32'd0, 1'b1);
      applyStimulus(1'b1, 32'd10, 32'hDEAD, 1'b1, 32'd1, 32'd99, 1'b1);
      for (int i = 0; i < 3; i++) begin
         checkOutput("drain_stall", stall_req, 1'b1);
         checkOutput("drain_ready", req_ready, 1'b0);
         checkOutput("drain_proto", proto_err, 1'b0);
         checkOutput("drain_halted", halted, 1'b0);
         if (i < 2) tick();
      end
      cons_ready = 1'b1;
      tick();
      checkOutput("drain_exit_kind", cons_kind, 2'd1);
      checkOutput("drain_exit_data", cons_data, 32'd0);
      checkOutput("drain_halted_pre", halted, 1'b0);
      checkOutput("drain_stall_pre", stall_req, 1'b1);
      tick();
      checkOutput("halt_halted", halted, 1'b1);
      checkOutput("halt_valid", cons_valid, 1'b0);
      checkOutput("halt_stall", stall_req, 1'b1);
      checkOutput("halt_ready", req_ready, 1'b0);
      checkOutput("halt_proto", proto_err, 1'b0);
      checkOutput("halt_queue", exp_q.size(), 0);
      applyStimulus(1'b1, 32'd1, 32'd5, 1'b1, 32'd1, 32'd6, 1'b0);
      tick();
      checkOutput("halt_req_proto", proto_err, 1'b0);
      checkOutput("halt_req_valid", cons_valid, 1'b0);
      checkOutput("halt_req_halted", halted, 1'b1);

      $display("[TB] wrap");
      doReset();
      checkOutput("wrap_rst_halted", halted, 1'b0);
      cons_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (i % 2 == 0)
            applyStimulus(1'b1, 32'd1, 32'd1000 + 32'(i), 1'b0, 32'd0, 32'd0, 1'b1);
         else
            applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 32'd1, 32'd1000 + 32'(i), 1'b1);
      end
      waitDrain(20);

      $display("[TB] reset mid-drain");
      cons_ready = 1'b0;
      applyStimulus(1'b1, 32'd1, 32'd1, 1'b1, 32'd1, 32'd2, 1'b1);
      applyStimulus(1'b1, 32'd1, 32'd3, 1'b0, 32'd0, 32'd0, 1'b1);
      rst = 1'b1;
      exp_q.delete();
      tick();
      checkOutput("midrst_valid", cons_valid, 1'b0);
      checkOutput("midrst_ready", req_ready, 1'b1);
      checkOutput("midrst_halted", halted, 1'b0);
      rst        = 1'b0;
      cons_ready = 1'b1;
      applyStimulus(1'b1, 32'd1, 32'd7777, 1'b0, 32'd0, 32'd0, 1'b1);
      waitDrain(20);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
